// File: rtl/mux_nx1_scan_pkg.sv
// Shared types and helpers for the scanning N:1 selector.
// State encoding and select-width helper.
package mux_nx1_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational W-bit N:1 selector.
// Indices at or above N select zero.
module mux_nx1 #(
  parameter int N  = 5,
  parameter int W  = 1,
  parameter int SW = 3
) (
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   y
);

  // Pick the matching channel, zero when none matches.
  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) y = in_data[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N:1 selector with manual and round-robin scan modes.
// FSM, dwell counter, channel register and output registers.
module mux_nx1_scan
  import mux_nx1_scan_pkg::*;
#(
  parameter int N     = 5,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SW    = sel_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   out,
  output logic           out_valid,
  output logic [SW-1:0]  ch,
  output logic           err,
  output logic           wrap
);

  localparam logic [SW:0]   NUM  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST = SW'(N-1);
  localparam logic [7:0]    DMAX = 8'(DWELL-1);

  state_t          state;
  state_t          state_n;
  logic [7:0]      cnt;
  logic [7:0]      cnt_n;
  logic [SW-1:0]   ch_n;
  logic [SW-1:0]   idx;
  logic [W-1:0]    y;
  logic            wrap_n;
  logic            sel_ok;

  assign sel_ok = {1'b0, sel} < NUM;

  // Next state, channel and dwell count; mode is sampled every edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ch_n    = ch;
    wrap_n  = 1'b0;
    if (!mode) begin
      state_n = MANUAL;
      cnt_n   = '0;
      if (sel_ok) ch_n = sel;
    end else begin
      state_n = SCAN;
      case (state)
        SCAN: begin
          if (!hold) begin
            if (cnt == DMAX) begin
              cnt_n  = '0;
              wrap_n = (ch == LAST);
              ch_n   = (ch == LAST) ? '0 : ch + SW'(1);
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end
        end
        default: begin
          ch_n  = '0;
          cnt_n = '0;
        end
      endcase
    end
  end

  // Manual uses sel directly; the mux zeroes out-of-range picks.
  assign idx = mode ? ch_n : sel;

  mux_nx1 #(
    .N (N),
    .W (W),
    .SW(SW)
  ) u_mux (
    .in_data(in_data),
    .idx    (idx),
    .y      (y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Counter, channel and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      ch        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      ch        <= ch_n;
      out       <= y;
      out_valid <= mode | sel_ok;
      err       <= ~mode & ~sel_ok;
      wrap      <= wrap_n;
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Self-checking bench for mux_nx1_scan.
// Random stimulus against a progress-count reference model.
module tb_mux_nx1_scan;

  localparam int N     = 5;
  localparam int W     = 8;
  localparam int DWELL = 4;
  localparam int SW    = 3;
  localparam int DW    = N*W;
  localparam int VW    = W+SW+3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic          hold = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] sel = '0;
  logic [W-1:0]  out;
  logic          out_valid;
  logic [SW-1:0] ch;
  logic          err;
  logic          wrap;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  m_out   = '0;
  logic          m_valid = 1'b0;
  logic          m_err   = 1'b0;
  logic          m_wrap  = 1'b0;
  logic          m_scan  = 1'b0;
  logic [SW-1:0] m_ch    = '0;
  int            m_t     = 0;

  mux_nx1_scan #(
    .N    (N),
    .W    (W),
    .DWELL(DWELL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .sel      (sel),
    .mode     (mode),
    .hold     (hold),
    .out      (out),
    .out_valid(out_valid),
    .ch       (ch),
    .err      (err),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] chan(
    input logic [DW-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  // Scan position is a count of non-held edges since scan entry.
  task automatic tick();
    logic          r, md, hd;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
    r = reset; md = mode; hd = hold; s = sel; d = in_data;
    @(posedge clk);
    if (r) begin
      m_out = '0; m_valid = 0; m_err = 0; m_wrap = 0;
      m_ch = '0; m_scan = 0; m_t = 0;
    end else if (!md) begin
      m_scan = 0;
      m_wrap = 0;
      if (int'(s) < N) begin
        m_ch = s; m_out = chan(d, int'(s));
        m_err = 0; m_valid = 1;
      end else begin
        m_out = '0; m_err = 1; m_valid = 0;
      end
    end else begin
      m_wrap = 0;
      if (!m_scan) begin
        m_scan = 1;
        m_t = 0;
      end else if (!hd) begin
        m_t++;
        m_wrap = (m_t % (N*DWELL)) == 0;
      end
      m_ch = SW'((m_t / DWELL) % N);
      m_out = chan(d, (m_t / DWELL) % N);
      m_valid = 1; m_err = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; mode = 1; in_data = rnd_data();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({out, out_valid, ch, err, wrap} !== VW'(0)) begin
        n_fail++;
        $display("FAIL reset_outs: got %h required 0",
          {out, out_valid, ch, err, wrap});
      end
    end
    reset = 0; mode = 0; sel = 1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out !== chan(in_data, 1)) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b out=%h required v=1 out=%h",
        out_valid, out, chan(in_data, 1));
    end
  endtask

  task automatic test_manual();
    mode = 0; hold = 0;
    in_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < N; k++) begin
      sel = SW'(k);
      tick();
      n_checks++;
      if (out !== W'(8'h11 * (k+1)) || err !== 1'b0 ||
          ch !== SW'(k)) begin
        n_fail++;
        $display("FAIL manual_fixed[%0d]: got out=%h err=%b ch=%0d required %h 0 %0d",
          k, out, err, ch, W'(8'h11 * (k+1)), k);
      end
    end
    for (int i = 0; i < 30; i++) begin
      in_data = rnd_data();
      sel = SW'($urandom_range(0, N-1));
      hold = 1'($urandom());
      tick();
      n_checks++;
      if ({out, out_valid, ch, err, wrap} !==
          {m_out, m_valid, m_ch, m_err, m_wrap}) begin
        n_fail++;
        $display("FAIL manual_rand[%0d]: got %h required %h", i,
          {out, out_valid, ch, err, wrap},
          {m_out, m_valid, m_ch, m_err, m_wrap});
      end
    end
    hold = 0;
  endtask

  task automatic test_invalid();
    mode = 0;
    in_data = '1;
    sel = 2;
    tick();
    for (int s = 5; s < 8; s++) begin
      sel = SW'(s);
      tick();
      n_checks++;
      if (out !== '0 || out_valid !== 1'b0 || err !== 1'b1 ||
          ch !== SW'(2)) begin
        n_fail++;
        $display("FAIL invalid_sel[%0d]: got out=%h v=%b err=%b ch=%0d required 0 0 1 2",
          s, out, out_valid, err, ch);
      end
    end
    sel = 2;
    tick();
    n_checks++;
    if (err !== 1'b0 || out !== 8'hFF || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_recover: got err=%b out=%h v=%b required 0 ff 1",
        err, out, out_valid);
    end
  endtask

  task automatic test_scan();
    int wraps;
    wraps = 0;
    reset = 1; tick(); reset = 0;
    mode = 1; hold = 0; sel = '0;
    for (int i = 0; i <= 2*N*DWELL; i++) begin
      in_data = rnd_data();
      tick();
      if (wrap === 1'b1) wraps++;
      n_checks++;
      if (ch !== SW'((i / DWELL) % N) ||
          {out, out_valid, err, wrap} !==
          {m_out, m_valid, m_err, m_wrap}) begin
        n_fail++;
        $display("FAIL scan[%0d]: got ch=%0d %h required ch=%0d %h",
          i, ch, {out, out_valid, err, wrap}, (i / DWELL) % N,
          {m_out, m_valid, m_err, m_wrap});
      end
    end
    n_checks++;
    if (wraps != 2) begin
      n_fail++;
      $display("FAIL scan_wraps: got %0d required 2", wraps);
    end
  endtask

  task automatic test_hold();
    reset = 1; tick(); reset = 0;
    mode = 1; hold = 0;
    tick();
    repeat (9) tick();
    n_checks++;
    if (ch !== SW'(2)) begin
      n_fail++;
      $display("FAIL hold_pre: got ch=%0d required 2", ch);
    end
    hold = 1;
    for (int i = 0; i < 6; i++) begin
      in_data[2*W +: W] = (i < 3) ? 8'h00 : 8'hAA;
      tick();
      n_checks++;
      if (ch !== SW'(2) || out !== ((i < 3) ? 8'h00 : 8'hAA)) begin
        n_fail++;
        $display("FAIL hold[%0d]: got ch=%0d out=%h required 2 %h",
          i, ch, out, (i < 3) ? 8'h00 : 8'hAA);
      end
    end
    hold = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ch !== ((i < 2) ? SW'(2) : SW'(3)) || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_release[%0d]: got ch=%0d wrap=%b required %0d 0",
          i, ch, wrap, (i < 2) ? 2 : 3);
      end
    end
  endtask

  task automatic test_disrupt();
    in_data = rnd_data();
    mode = 0; sel = 3;
    tick();
    n_checks++;
    if (out !== chan(in_data, 3) || ch !== SW'(3) || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL disrupt_manual: got out=%h ch=%0d v=%b required %h 3 1",
        out, ch, out_valid, chan(in_data, 3));
    end
    mode = 1;
    tick();
    n_checks++;
    if (ch !== '0 || out !== chan(in_data, 0)) begin
      n_fail++;
      $display("FAIL disrupt_rescan: got ch=%0d out=%h required 0 %h",
        ch, out, chan(in_data, 0));
    end
    repeat (5) tick();
    reset = 1;
    tick();
    n_checks++;
    if ({out, out_valid, ch, err, wrap} !== VW'(0)) begin
      n_fail++;
      $display("FAIL disrupt_reset: got %h required 0",
        {out, out_valid, ch, err, wrap});
    end
    reset = 0;
  endtask

  task automatic test_random();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 400; i++) begin
      in_data = rnd_data();
      sel   = SW'($urandom_range(0, 7));
      hold  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      tick();
      n_checks++;
      if ({out, out_valid, ch, err, wrap} !==
          {m_out, m_valid, m_ch, m_err, m_wrap}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h required %h", i,
          {out, out_valid, ch, err, wrap},
          {m_out, m_valid, m_ch, m_err, m_wrap});
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_invalid();
    test_scan();
    test_hold();
    test_disrupt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
